hs_fifo_pfifo: RTL and testbench
================================

// Module: hs_fifo_pfifo
// PURPOSE
//  Synchronous packet FIFO: successor to the single-channel sync FIFO, with a cut-through or store-and-forward mode.
//  Store-and-forward mode exposes a packet only after its last beat commits; wdrop discards the in-flight packet.
//  Oversize packets are auto-discarded and flagged. Sits between packet producers/consumers on one clock domain.
// PARAMETERS
//  DATA_W     8  data beat width (bits)
//  DEPTH      16 entries; power of 2, >=2
//  AF_THRESH  12 walmost_full when level >= AF_THRESH
//  AE_THRESH  2  ralmost_empty when visible count <= AE_THRESH
//  STORE_FWD  1  1: store-and-forward; 0: cut-through (wdrop ignored, no oversize check)
//  LW = $clog2(DEPTH+1) (localparam)
// PORTS
//  clk            in   1       clock; all logic on posedge
//  sreset         in   1       synchronous reset, active-high
//  wvalid         in   1       write beat valid
//  wready         out  1       write beat accepted when wvalid&&wready
//  wdata          in   DATA_W  write data
//  wlast          in   1       last beat of packet
//  wdrop          in   1       discard current in-flight packet (STORE_FWD=1)
//  walmost_full   out  1       level >= AF_THRESH
//  wovf           out  1       one-cycle pulse: oversize packet discarded
//  rready         in   1       read beat handshake when rvalid&&rready
//  rvalid         out  1       visible beat available
//  rdata          out  DATA_W  head data
//  rlast          out  1       head is last beat of packet
//  rpeek          in   1       with handshake: observe head without popping
//  ralmost_empty  out  1       visible count <= AE_THRESH
//  level          out  LW      all stored entries, incl. uncommitted
//  pkt_cnt        out  LW      complete packets stored (wlast beats committed, not popped)
// BEHAVIOUR
//  Reset (sreset, sync): wr_spec/wr_cmt/rd pointers=0, state=IDLE, pkt_cnt=0 -> wready=1, rvalid=0, level=0,
//   walmost_full=(AF_THRESH==0), ralmost_empty=1, wovf=0. Storage not reset; rdata/rlast don't-care while rvalid=0.
//   Reset mid-packet: partial and committed data all lost.
//  Pointers AW+1 bits (wrap bit); level=wr_spec-rd; visible=wr_cmt-rd (STORE_FWD=0: wr_cmt==wr_spec).
//  Flags/wready/rvalid combinational from registered pointers only; no same-cycle bypass.
//  wready = (level<DEPTH) || state==DISCARD. rvalid = visible>0. rdata/rlast = mem[rd] (async read).
//  Write accept: store {wlast,wdata} at wr_spec, wr_spec++. Beat visible on rvalid the cycle after acceptance edge (latency 1).
//  STORE_FWD=1 write FSM:
//   IDLE/PKT: accepted beat -> PKT; wlast&&!wdrop -> wr_cmt<=wr_spec+1, pkt_cnt++, ->IDLE.
//   accepted beat with wdrop (wlast irrelevant; drop wins): wr_spec<=wr_cmt, ->IDLE.
//   accepted non-last beat making level==DEPTH with visible==0 (oversize): wr_spec<=wr_cmt, wovf=1 one cycle, ->DISCARD.
//   DISCARD: wready=1, beats accepted and dropped (not stored); wlast beat -> IDLE.
//  STORE_FWD=0: every accepted beat commits; wlast increments pkt_cnt; wdrop ignored; wovf stays 0.
//  Read: handshake with !rpeek pops: rd++, pkt_cnt-- if rlast. With rpeek: no pointer change (head re-presented).
//  Simultaneous commit and pop of a last beat: pkt_cnt unchanged. Simultaneous write+pop: level unchanged.
//  Full (level==DEPTH): wready=0 even if a pop occurs that cycle; wready rises next cycle.
//  Store-and-forward: packets > DEPTH beats never emitted; packets <= DEPTH beats never lost.
//  Assertions: rvalid&&!rready |=> stable rdata/rlast; level<=DEPTH; pkt_cnt<=visible.
// TESTING (DATA_W=8, DEPTH=8, AF_THRESH=6, AE_THRESH=1)
//  SF: write 0x11,0x22,0x33(wlast) -> rvalid=0 until cycle after 0x33 accepted; read 11,22,33, rlast on 33; pkt_cnt 1->0.
//  SF: 4-beat packet, wdrop on beat 2, then 0xA0(wlast) -> level 0 after drop edge; only 0xA0 read, rlast=1.
//  SF: 10-beat packet -> wovf pulse on beat-8 edge; beats 9,10 accepted+dropped; level=0; next 0x5A(wlast) reads fine.
//  CT: write 8 beats, no reads -> rvalid after beat 1; walmost_full at level 6; wready=0 at 8; 1 pop -> wready=1 next cycle.
//  Head 0x55: rready=1,rpeek=1 for 3 cycles -> rdata=0x55, level constant; rready=1,rpeek=0 -> pops, level-1.
//  1 committed packet + 2 beats in flight, sreset 1 cycle -> level=0, pkt_cnt=0, rvalid=0, wready=1; new packet reads OK.

Source files
------------

// File: rtl/hs_fifo_pfifo.sv
// Synchronous packet FIFO with store-and-forward (STORE_FWD=1) or cut-through (STORE_FWD=0) mode.
// Store-and-forward exposes a packet only once its last beat commits; oversize packets are dropped and flagged.
module hs_fifo_pfifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2,
    parameter int STORE_FWD = 1,
    localparam int LW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              sreset,
    input  logic              wvalid,
    output logic              wready,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wlast,
    input  logic              wdrop,
    output logic              walmost_full,
    output logic              wovf,
    input  logic              rready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              rlast,
    input  logic              rpeek,
    output logic              ralmost_empty,
    output logic [LW-1:0]     level,
    output logic [LW-1:0]     pkt_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, PKT, DISCARD} wstate_t;

    wstate_t           state, state_n;
    logic [AW:0]       wr_spec, wr_spec_n;
    logic [AW:0]       wr_cmt, wr_cmt_n;
    logic [AW:0]       rd, rd_n;
    logic [LW-1:0]     pkt_cnt_n;
    logic [LW-1:0]     visible;
    logic              wovf_n;
    logic              mem_we;
    logic              wr_acc;
    logic              pop;
    logic              pkt_inc;
    logic              pkt_dec;
    logic [DATA_W:0]   mem [DEPTH];

    // wr_spec runs ahead of wr_cmt by the uncommitted part of the in-flight packet
    assign level         = wr_spec - rd;
    assign visible       = wr_cmt - rd;
    assign wready        = (int'(level) < DEPTH) || (state == DISCARD);
    assign rvalid        = (visible != '0);
    assign walmost_full  = (int'(level) >= AF_THRESH);
    assign ralmost_empty = (int'(visible) <= AE_THRESH);
    assign {rlast, rdata} = mem[rd[AW-1:0]];

    assign wr_acc  = wvalid && wready;
    assign pop     = rvalid && rready && !rpeek;
    assign pkt_dec = pop && rlast;

    always_comb begin
        state_n   = state;
        wr_spec_n = wr_spec;
        wr_cmt_n  = wr_cmt;
        rd_n      = rd;
        wovf_n    = 1'b0;
        mem_we    = 1'b0;
        pkt_inc   = 1'b0;
        if (pop) begin
            rd_n = rd + 1'b1;
        end
        if (wr_acc) begin
            if (STORE_FWD == 0) begin
                mem_we    = 1'b1;
                wr_spec_n = wr_spec + 1'b1;
                wr_cmt_n  = wr_spec + 1'b1;
                pkt_inc   = wlast;
            end else begin
                unique case (state)
                    DISCARD: begin
                        if (wlast) state_n = IDLE;
                    end
                    default: begin
                        if (wdrop) begin
                            wr_spec_n = wr_cmt;
                            state_n   = IDLE;
                        end else if (wlast) begin
                            mem_we    = 1'b1;
                            wr_spec_n = wr_spec + 1'b1;
                            wr_cmt_n  = wr_spec + 1'b1;
                            pkt_inc   = 1'b1;
                            state_n   = IDLE;
                        end else if ((int'(level) == DEPTH - 1) && (visible == '0)) begin
                            // packet alone fills the FIFO without a last beat: it can never commit
                            wr_spec_n = wr_cmt;
                            wovf_n    = 1'b1;
                            state_n   = DISCARD;
                        end else begin
                            mem_we    = 1'b1;
                            wr_spec_n = wr_spec + 1'b1;
                            state_n   = PKT;
                        end
                    end
                endcase
            end
        end
        unique case ({pkt_inc, pkt_dec})
            2'b10:   pkt_cnt_n = pkt_cnt + 1'b1;
            2'b01:   pkt_cnt_n = pkt_cnt - 1'b1;
            default: pkt_cnt_n = pkt_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state   <= IDLE;
            wr_spec <= '0;
            wr_cmt  <= '0;
            rd      <= '0;
            pkt_cnt <= '0;
            wovf    <= 1'b0;
        end else begin
            state   <= state_n;
            wr_spec <= wr_spec_n;
            wr_cmt  <= wr_cmt_n;
            rd      <= rd_n;
            pkt_cnt <= pkt_cnt_n;
            wovf    <= wovf_n;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_spec[AW-1:0]] <= {wlast, wdata};
    end

    a_head_stable: assert property (@(posedge clk) disable iff (sreset)
        rvalid && !rready |=> $stable(rdata) && $stable(rlast));
    a_level_max: assert property (@(posedge clk) disable iff (sreset)
        int'(level) <= DEPTH);
    a_pkt_vis: assert property (@(posedge clk) disable iff (sreset)
        pkt_cnt <= visible);

endmodule

// File: tb/tb_hs_fifo_pfifo.sv
// Bench for hs_fifo_pfifo: one store-and-forward and one cut-through instance, exercised one at a time
// against a queue-based packet model; a negedge monitor checks status and scoreboards popped beats.
module tb_hs_fifo_pfifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          sreset = 1'b1;
    logic          mode_ct = 1'b0;
    logic          wvalid = 1'b0, wlast = 1'b0, wdrop = 1'b0;
    logic          rready = 1'b0, rpeek = 1'b0;
    logic [DW-1:0] wdata = '0;

    logic          sf_wvalid, sf_rready, ct_wvalid, ct_rready;
    logic          sf_wready, sf_af, sf_ovf, sf_rvalid, sf_rlast, sf_ae;
    logic          ct_wready, ct_af, ct_ovf, ct_rvalid, ct_rlast, ct_ae;
    logic [DW-1:0] sf_rdata, ct_rdata;
    logic [LW-1:0] sf_level, sf_pkt, ct_level, ct_pkt;

    logic          m_wready, m_af, m_ovf, m_rvalid, m_rlast, m_ae;
    logic [DW-1:0] m_rdata;
    logic [LW-1:0] m_level, m_pkt;

    always #5 clk = ~clk;

    assign sf_wvalid = wvalid & ~mode_ct;
    assign sf_rready = rready & ~mode_ct;
    assign ct_wvalid = wvalid & mode_ct;
    assign ct_rready = rready & mode_ct;

    assign m_wready = mode_ct ? ct_wready : sf_wready;
    assign m_af     = mode_ct ? ct_af     : sf_af;
    assign m_ovf    = mode_ct ? ct_ovf    : sf_ovf;
    assign m_rvalid = mode_ct ? ct_rvalid : sf_rvalid;
    assign m_rlast  = mode_ct ? ct_rlast  : sf_rlast;
    assign m_ae     = mode_ct ? ct_ae     : sf_ae;
    assign m_rdata  = mode_ct ? ct_rdata  : sf_rdata;
    assign m_level  = mode_ct ? ct_level  : sf_level;
    assign m_pkt    = mode_ct ? ct_pkt    : sf_pkt;

    hs_fifo_pfifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .STORE_FWD(1)) u_sf (
        .clk(clk), .sreset(sreset), .wvalid(sf_wvalid), .wready(sf_wready), .wdata(wdata),
        .wlast(wlast), .wdrop(wdrop), .walmost_full(sf_af), .wovf(sf_ovf), .rready(sf_rready),
        .rvalid(sf_rvalid), .rdata(sf_rdata), .rlast(sf_rlast), .rpeek(rpeek),
        .ralmost_empty(sf_ae), .level(sf_level), .pkt_cnt(sf_pkt));

    hs_fifo_pfifo #(.DATA_W(DW), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .STORE_FWD(0)) u_ct (
        .clk(clk), .sreset(sreset), .wvalid(ct_wvalid), .wready(ct_wready), .wdata(wdata),
        .wlast(wlast), .wdrop(wdrop), .walmost_full(ct_af), .wovf(ct_ovf), .rready(ct_rready),
        .rvalid(ct_rvalid), .rdata(ct_rdata), .rlast(ct_rlast), .rpeek(rpeek),
        .ralmost_empty(ct_ae), .level(ct_level), .pkt_cnt(ct_pkt));

    // Reference model: committed beats (visible, in read order) and the open packet's beats
    logic [DW:0]   exp_q[$];
    logic [DW:0]   pend_q[$];
    bit            discarding = 1'b0;
    bit            ovf_exp = 1'b0;

    bit            c_rst = 1'b1, c_acc = 1'b0, c_last = 1'b0, c_drop = 1'b0;
    logic [DW-1:0] c_data = '0;
    int            c_lvl = 0, c_vis = 0;

    int            checks = 0;
    int            failures = 0;
    int            rd_prob = 0;
    int            pk_prob = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int cnt_last();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i][DW]) n++;
        return n;
    endfunction

    // Monitor: status checks against the model, then scoreboard any beat popped at the coming edge
    always @(negedge clk) begin
        logic [DW:0] e;
        c_rst  = sreset;
        c_acc  = wvalid && m_wready && !sreset;
        c_data = wdata;
        c_last = wlast;
        c_drop = wdrop;
        c_lvl  = exp_q.size() + pend_q.size();
        c_vis  = exp_q.size();
        if (!sreset) begin
            chk("wready", int'(m_wready), int'((c_lvl < DEPTH) || discarding));
            chk("rvalid", int'(m_rvalid), int'(c_vis > 0));
            chk("level", int'(m_level), c_lvl);
            chk("pkt_cnt", int'(m_pkt), cnt_last());
            chk("walmost_full", int'(m_af), int'(c_lvl >= AF));
            chk("ralmost_empty", int'(m_ae), int'(c_vis <= AE));
            chk("wovf", int'(m_ovf), int'(ovf_exp));
            if (m_rvalid && rready && !rpeek) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop: DUT popped data=%0h but model holds no visible beat at %0t", m_rdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("rdata", int'(m_rdata), int'(e[DW-1:0]));
                    chk("rlast", int'(m_rlast), int'(e[DW]));
                end
            end
        end
    end

    // Model update at the clock edge from the values captured at the preceding negedge
    always @(posedge clk) begin
        ovf_exp = 1'b0;
        if (c_rst) begin
            exp_q.delete();
            pend_q.delete();
            discarding = 1'b0;
        end else if (c_acc) begin
            if (mode_ct) begin
                exp_q.push_back({c_last, c_data});
            end else if (discarding) begin
                if (c_last) discarding = 1'b0;
            end else if (c_drop) begin
                pend_q.delete();
            end else if (c_last) begin
                foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
                exp_q.push_back({1'b1, c_data});
                pend_q.delete();
            end else if (c_lvl + 1 == DEPTH && c_vis == 0) begin
                pend_q.delete();
                discarding = 1'b1;
                ovf_exp = 1'b1;
            end else begin
                pend_q.push_back({1'b0, c_data});
            end
        end
    end

    // Reader: drives rready/rpeek after the knobs settle for the cycle
    initial begin
        forever begin
            @(posedge clk);
            #2;
            rready = ($urandom_range(0, 99) < rd_prob);
            rpeek  = ($urandom_range(0, 99) < pk_prob);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input bit last, input bit drop);
        bit done = 1'b0;
        int n = 0;
        wvalid = 1'b1;
        wdata  = d;
        wlast  = last;
        wdrop  = drop;
        while (!done) begin
            @(negedge clk);
            done = m_wready;
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 300) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: wready stayed %0d for %0d cycles, required 1", m_wready, n);
                done = 1'b1;
            end
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        wdrop  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rd_prob = 100;
        pk_prob = 0;
        while ((exp_q.size() != 0 || pend_q.size() != 0) && n < 500) begin
            idle(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || pend_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d beats remain, required 0", exp_q.size() + pend_q.size());
        end
        idle(2);
        rd_prob = 0;
    endtask

    task automatic do_reset(input bit ct);
        sreset  = 1'b1;
        mode_ct = ct;
        idle(2);
        sreset  = 1'b0;
        idle(1);
    endtask

    task automatic random_pkts(input int npkt, input int maxlen);
        int len;
        bit drop;
        for (int p = 0; p < npkt; p++) begin
            rd_prob = $urandom_range(20, 100);
            pk_prob = 10;
            len = $urandom_range(1, maxlen);
            for (int b = 0; b < len; b++) begin
                drop = ($urandom_range(0, 19) == 0);
                send(8'($urandom), b == len - 1, drop);
                if (drop && !mode_ct) break;
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        drain();
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset(1'b0);

        // three-beat packet stays invisible until its last beat commits
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b0, 1'b0);
        send(8'h33, 1'b1, 1'b0);
        idle(2);
        drain();

        // dropped packet vanishes, following packet is intact
        send(8'h01, 1'b0, 1'b0);
        send(8'h02, 1'b0, 1'b1);
        send(8'hA0, 1'b1, 1'b0);
        idle(1);
        drain();

        // ten-beat packet overflows an empty 8-deep FIFO and is discarded
        for (int i = 1; i <= 10; i++) send(8'(i), i == 10, 1'b0);
        send(8'h5A, 1'b1, 1'b0);
        idle(1);
        drain();

        // a full DEPTH-beat packet must survive
        for (int i = 0; i < DEPTH; i++) send(8'(8'hC0 + i), i == DEPTH - 1, 1'b0);
        drain();

        // peek holds the head in place
        send(8'h55, 1'b1, 1'b0);
        idle(2);
        pk_prob = 100;
        rd_prob = 100;
        idle(3);
        pk_prob = 0;
        drain();

        // reset with one committed packet and two beats in flight
        send(8'h71, 1'b0, 1'b0);
        send(8'h72, 1'b1, 1'b0);
        send(8'h73, 1'b0, 1'b0);
        send(8'h74, 1'b0, 1'b0);
        sreset = 1'b1;
        idle(1);
        sreset = 1'b0;
        idle(1);
        send(8'h81, 1'b0, 1'b0);
        send(8'h82, 1'b1, 1'b0);
        drain();

        random_pkts(120, DEPTH);

        // cut-through instance
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) send(8'(8'h90 + i), i == 7, 1'b0);
        idle(2);
        rd_prob = 100;
        idle(1);
        rd_prob = 0;
        idle(2);
        drain();

        send(8'hE1, 1'b0, 1'b1);
        send(8'hE2, 1'b1, 1'b0);
        drain();

        random_pkts(100, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit, checks=%0d", checks);
        $fatal(1, "global timeout");
    end

endmodule
